// File: rtl/mmu_feeder_nxn.sv
// Feeder for an N x N systolic MMU: snapshots A/B, streams them in with diagonal
// skew, waits for the array to drain, then returns results to the host one element per beat.
module mmu_feeder_nxn #(
    parameter int N   = 2,
    parameter int DW  = 8,
    parameter int CW  = 8,
    parameter int LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic [N*N-1:0][DW-1:0]  weight,
    input  logic [N*N-1:0][DW-1:0]  inputs,
    input  logic [N*N-1:0][CW-1:0]  c,
    output logic                    busy,
    output logic                    clear,
    output logic [N-1:0][DW-1:0]    a_data,
    output logic [N-1:0][DW-1:0]    b_data,
    output logic                    host_valid,
    input  logic                    host_ready,
    output logic [CW-1:0]           host_outdata,
    output logic                    host_last,
    output logic                    done
);

    localparam int KW = $clog2(2*N-1);
    localparam int IW = $clog2(N*N);
    localparam int WW = (LAT > 0) ? $clog2(LAT+1) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, OUT} state_t;

    state_t                   state_q, state_n;
    logic [KW-1:0]            k_q, k_n;
    logic [IW-1:0]            idx_q, idx_n;
    logic [WW-1:0]            wcnt_q, wcnt_n;
    logic [N*N-1:0][DW-1:0]   a_q, a_n, b_q, b_n;
    logic [N*N-1:0][CW-1:0]   snap_q, snap_n;
    logic                     busy_n, clear_n, valid_n, last_n, done_n, go_out;
    logic [N-1:0][DW-1:0]     a_data_n, b_data_n;
    logic [CW-1:0]            outdata_n;

    // Row i sees A[i][k-i]; lanes outside the diagonal band carry zero.
    function automatic logic [N-1:0][DW-1:0] skew_a(input logic [N*N-1:0][DW-1:0] m, input int kk);
        logic [N-1:0][DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int d = 0; d < N; d++)
                if (d == kk - i) r[i] = m[IW'(i*N + d)];
        return r;
    endfunction

    // Column j sees B[k-j][j].
    function automatic logic [N-1:0][DW-1:0] skew_b(input logic [N*N-1:0][DW-1:0] m, input int kk);
        logic [N-1:0][DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            for (int d = 0; d < N; d++)
                if (d == kk - j) r[j] = m[IW'(d*N + j)];
        return r;
    endfunction

    always_comb begin
        state_n   = state_q;
        k_n       = k_q;
        idx_n     = idx_q;
        wcnt_n    = wcnt_q;
        a_n       = a_q;
        b_n       = b_q;
        snap_n    = snap_q;
        clear_n   = 1'b0;
        a_data_n  = '0;
        b_data_n  = '0;
        valid_n   = 1'b0;
        last_n    = 1'b0;
        done_n    = 1'b0;
        outdata_n = host_outdata;
        go_out    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_n     = inputs;
                b_n     = weight;
                clear_n = 1'b1;
                state_n = CLEAR;
            end
            CLEAR: begin
                k_n      = '0;
                a_data_n = skew_a(a_q, 0);
                b_data_n = skew_b(b_q, 0);
                state_n  = FEED;
            end
            FEED: begin
                if (int'(k_q) == 2*N-2) begin
                    if (LAT == 0) go_out = 1'b1;
                    else begin
                        wcnt_n  = '0;
                        state_n = WAIT;
                    end
                end else begin
                    k_n      = k_q + 1'b1;
                    a_data_n = skew_a(a_q, int'(k_q) + 1);
                    b_data_n = skew_b(b_q, int'(k_q) + 1);
                end
            end
            WAIT: begin
                if (int'(wcnt_q) == LAT - 1) go_out = 1'b1;
                else wcnt_n = wcnt_q + 1'b1;
            end
            OUT: begin
                valid_n = 1'b1;
                last_n  = host_last;
                if (host_ready) begin
                    if (int'(idx_q) == N*N-1) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n     = idx_q + 1'b1;
                        outdata_n = snap_q[idx_n];
                        last_n    = (int'(idx_n) == N*N-1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // First beat comes straight from c since the snapshot lands on this same edge.
        if (go_out) begin
            snap_n    = c;
            idx_n     = '0;
            valid_n   = 1'b1;
            outdata_n = c[0];
            state_n   = OUT;
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            idx_q        <= '0;
            wcnt_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            snap_q       <= '0;
            busy         <= 1'b0;
            clear        <= 1'b0;
            a_data       <= '0;
            b_data       <= '0;
            host_valid   <= 1'b0;
            host_outdata <= '0;
            host_last    <= 1'b0;
            done         <= 1'b0;
        end else if (en) begin
            state_q      <= state_n;
            k_q          <= k_n;
            idx_q        <= idx_n;
            wcnt_q       <= wcnt_n;
            a_q          <= a_n;
            b_q          <= b_n;
            snap_q       <= snap_n;
            busy         <= busy_n;
            clear        <= clear_n;
            a_data       <= a_data_n;
            b_data       <= b_data_n;
            host_valid   <= valid_n;
            host_outdata <= outdata_n;
            host_last    <= last_n;
            done         <= done_n;
        end
    end

endmodule
